// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard scoreboard.
//   hz_state_e  : issue controller state (RUN / DRAIN / HALTED)
//   sb_entry_t  : one scoreboard entry (valid, rd, rd_we, is_load, is_halt)
//   sel_width() : forwarding select width, max(1, clog2(stages))
//   SEL_REGFILE : forwarding select value meaning "use the ID/EX register value"
package hazard_pkg;

  // Storage width of the rd field inside a scoreboard entry. Register
  // addresses narrower than this are zero-extended on entry.
  localparam int SB_RD_W = 8;

  localparam int SEL_REGFILE = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               rd_we;
    logic               is_load;
    logic               is_halt;
  } sb_entry_t;

  function automatic int sel_width(input int stages);
    int w;
    w = $clog2(stages);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// hz_stage_reg: one scoreboard entry register.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the entry
//   load : 1 = capture d, 0 = capture a bubble (all-zero entry)
//   d    : incoming entry
//   q    : stored entry
module hz_stage_reg
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  sb_entry_t d,
  output sb_entry_t q
);

  sb_entry_t q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end else begin
      q_reg <= '0;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue / stall / flush / forwarding / halt controller for
// an in-order pipeline. Every instruction past decode is tracked in a
// FWD_STAGES-deep scoreboard shift register (stage 0 = EX, last = WB).
//   clk, rst      : clock, synchronous active-high reset
//   id_*          : decode-stage instruction (valid, sources, dest, kind)
//   ex_mispredict : branch in EX resolved opposite to prediction
//   issue/stall/flush/fetch_hold : combinational pipeline controls
//   halt          : registered, high once the halt instruction has retired
//   fwd_sel       : registered per-source EX operand select (0 = ID/EX value,
//                   k = output register of stage k)
//   stg_valid     : scoreboard valid bits (debug)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      id_is_halt,
  input  logic                      ex_mispredict,
  output logic                      issue,
  output logic                      stall,
  output logic                      flush,
  output logic                      fetch_hold,
  output logic                      halt,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [FWD_STAGES-1:0]     stg_valid
);

  localparam int LAST = FWD_STAGES - 1;

  // ---------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------
  sb_entry_t id_entry;
  sb_entry_t stg_d [FWD_STAGES];
  sb_entry_t stg_q [FWD_STAGES];
  logic [FWD_STAGES-1:0] stg_load;

  assign id_entry = '{valid:   1'b1,
                      rd:      SB_RD_W'(id_rd),
                      rd_we:   id_rd_we,
                      is_load: id_is_load,
                      is_halt: id_is_halt};

  genvar gi, gk;
  generate
    for (gi = 0; gi < FWD_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // Stage 0 takes the decode instruction only when it issues,
        // otherwise a bubble enters EX.
        assign stg_d[gi]    = id_entry;
        assign stg_load[gi] = issue;
      end else begin : g_tail
        // Later stages shift unconditionally.
        assign stg_d[gi]    = stg_q[gi-1];
        assign stg_load[gi] = 1'b1;
      end

      hz_stage_reg u_stage (
        .clk  (clk),
        .rst  (rst),
        .load (stg_load[gi]),
        .d    (stg_d[gi]),
        .q    (stg_q[gi])
      );

      assign stg_valid[gi] = stg_q[gi].valid;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Source / stage match matrix
  // ---------------------------------------------------------------------
  logic [NUM_SRC-1:0][FWD_STAGES-1:0] match;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      for (gk = 0; gk < FWD_STAGES; gk++) begin : g_stg
        assign match[gi][gk] = id_rs_used[gi]
                             & stg_q[gk].valid
                             & stg_q[gk].rd_we
                             & (stg_q[gk].rd != '0)
                             & (stg_q[gk].rd == SB_RD_W'(id_rs_addr[gi*REG_AW +: REG_AW]));
      end
    end
  endgenerate

  // Load-use: a load whose data is not yet forwardable (still within the
  // first LOAD_LAT stages) feeding a decode source.
  logic load_hazard;

  always_comb begin
    load_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (match[i][k] && stg_q[k].is_load) begin
          load_hazard = 1'b1;
        end
      end
    end
  end

  // Forwarding select: walk from oldest forwardable stage to youngest so the
  // youngest producer overwrites. The last stage is skipped because the
  // register file is write-through.
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_calc;

  always_comb begin
    sel_calc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES - 2; k >= 0; k--) begin
        if (match[i][k]) begin
          sel_calc[i] = SEL_W'(k + 1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Issue controller FSM
  // ---------------------------------------------------------------------
  hz_state_e state_reg, state_next;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_reg;
  // Set the cycle after the halt entry sat in the last stage, i.e. once the
  // halt has retired; DRAIN leaves on this flag.
  logic halt_retire_reg;

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    fetch_hold = 1'b0;
    case (state_reg)
      RUN: begin
        // Flush dominates stall and halt issue.
        flush = ex_mispredict;
        stall = load_hazard & ~ex_mispredict;
        issue = id_valid & ~ex_mispredict & ~(load_hazard & ~ex_mispredict);
        if (issue && id_is_halt) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        fetch_hold = 1'b1;
        if (halt_retire_reg) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        fetch_hold = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      fwd_sel_reg     <= '0;
      halt_retire_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fwd_sel_reg     <= issue ? sel_calc : '0;
      halt_retire_reg <= stg_q[LAST].valid & stg_q[LAST].is_halt;
    end
  end

  assign fwd_sel = fwd_sel_reg;
  assign halt    = (state_reg == HALTED);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus hand-written halt / reset
// sequences for hazard_scoreboard (defaults) and a LOAD_LAT=0 instance.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int FS = 3;
  localparam int SW = sel_width(FS);

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [NS*AW-1:0] id_rs_addr;
  logic [NS-1:0] id_rs_used;
  logic [AW-1:0] id_rd;
  logic id_rd_we, id_is_load, id_is_halt, ex_mispredict;

  logic issue, stall, flush, fetch_hold, halt;
  logic [NS*SW-1:0] fwd_sel;
  logic [FS-1:0] stg_valid;

  logic issue_l0, stall_l0, flush_l0, fetch_hold_l0, halt_l0;
  logic [NS*SW-1:0] fwd_sel_l0;
  logic [FS-1:0] stg_valid_l0;

  int n_checks = 0;
  int n_errors = 0;
  logic [FS-1:0] exp_stg;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .ex_mispredict(ex_mispredict),
    .issue(issue), .stall(stall), .flush(flush), .fetch_hold(fetch_hold),
    .halt(halt), .fwd_sel(fwd_sel), .stg_valid(stg_valid)
  );

  hazard_scoreboard #(.REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .LOAD_LAT(0)) dut_l0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .ex_mispredict(ex_mispredict),
    .issue(issue_l0), .stall(stall_l0), .flush(flush_l0), .fetch_hold(fetch_hold_l0),
    .halt(halt_l0), .fwd_sel(fwd_sel_l0), .stg_valid(stg_valid_l0)
  );

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs0, rs1;
    logic [1:0] u;
    logic [4:0] rd;
    logic       we, ld, ht, mp;
    logic       e_iss, e_stl, e_fl;
    int         e_s0, e_s1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic v, int rs0, int rs1, logic [1:0] u,
                              int rd, logic we, logic ld, logic ht, logic mp,
                              logic iss, logic stl, logic fl, int s0, int s1);
    vec_t t;
    t.name = name; t.v = v; t.rs0 = 5'(rs0); t.rs1 = 5'(rs1); t.u = u;
    t.rd = 5'(rd); t.we = we; t.ld = ld; t.ht = ht; t.mp = mp;
    t.e_iss = iss; t.e_stl = stl; t.e_fl = fl; t.e_s0 = s0; t.e_s1 = s1;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs_addr = '0; id_rs_used = '0; id_rd = '0;
    id_rd_we = 1'b0; id_is_load = 1'b0; id_is_halt = 1'b0; ex_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    exp_stg = '0;
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; id_rs_addr = {t.rs1, t.rs0}; id_rs_used = t.u; id_rd = t.rd;
    id_rd_we = t.we; id_is_load = t.ld; id_is_halt = t.ht; ex_mispredict = t.mp;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      apply(vecs[r]);
      #4;
      chk({vecs[r].name, ".issue"}, int'(issue), int'(vecs[r].e_iss));
      chk({vecs[r].name, ".stall"}, int'(stall), int'(vecs[r].e_stl));
      chk({vecs[r].name, ".flush"}, int'(flush), int'(vecs[r].e_fl));
      chk({vecs[r].name, ".fetch_hold"}, int'(fetch_hold), 0);
      step();
      exp_stg = {exp_stg[FS-2:0], vecs[r].e_iss};
      chk({vecs[r].name, ".sel0"}, int'(fwd_sel[SW-1:0]), vecs[r].e_s0);
      chk({vecs[r].name, ".sel1"}, int'(fwd_sel[2*SW-1:SW]), vecs[r].e_s1);
      chk({vecs[r].name, ".stg_valid"}, int'(stg_valid), int'(exp_stg));
      $display("row %0d %s: issue=%0b stall=%0b flush=%0b sel=%0d/%0d stg_valid=%b",
               r, vecs[r].name, vecs[r].e_iss, vecs[r].e_stl, vecs[r].e_fl,
               fwd_sel[SW-1:0], fwd_sel[2*SW-1:SW], stg_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        name          v rs0 rs1 u     rd we ld ht mp  iss stl fl s0 s1
    vecs.push_back(mk("addi_x5",   1, 0, 0, 2'b01, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("add_x6_x5", 1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lw_x6",     1, 1, 0, 2'b01, 6, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("add_x7_stl",1, 6, 0, 2'b11, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("add_x7_iss",1, 6, 0, 2'b11, 7, 1, 0, 0, 0, 1, 0, 0, 2, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("addi_x7_a", 1, 0, 0, 2'b01, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("addi_x7_b", 1, 0, 0, 2'b01, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("add_x8_x7", 1, 7, 0, 2'b11, 8, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("addi_x0",   1, 0, 0, 2'b01, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("add_x9_x0", 1, 0, 0, 2'b11, 9, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("add_x10_wb",1, 8, 0, 2'b11,10, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("add_x11",   1, 9,10, 2'b11,11, 1, 0, 0, 0, 1, 0, 0, 2, 1));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lw_x12",    1, 0, 0, 2'b01,12, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("use_mispr", 1,12, 0, 2'b11,13, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("use_after", 1,12, 0, 2'b11,13, 1, 0, 0, 0, 1, 0, 0, 2, 0));
    vecs.push_back(mk("halt_mispr",1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("bubble",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lw_x14",    1, 0, 0, 2'b01,14, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("halt_stall",1,14, 0, 2'b01, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));

    // Reset state
    rst = 1'b1;
    idle();
    step();
    #4;
    chk("rst.stg_valid", int'(stg_valid), 0);
    chk("rst.fwd_sel", int'(fwd_sel), 0);
    chk("rst.halt", int'(halt), 0);
    chk("rst.fetch_hold", int'(fetch_hold), 0);
    chk("rst.stall", int'(stall), 0);
    chk("rst.flush", int'(flush), 0);
    chk("rst.issue", int'(issue), 0);
    rst = 1'b0;
    step();

    // LOAD_LAT=0: load result forwardable straight from EX/MEM
    apply(vecs[5]);
    step();
    apply(vecs[6]);
    #4;
    chk("l0.stall", int'(stall_l0), 0);
    chk("l0.issue", int'(issue_l0), 1);
    chk("l1.stall", int'(stall), 1);
    step();
    chk("l0.sel0", int'(fwd_sel_l0[SW-1:0]), 1);
    chk("l0.sel1", int'(fwd_sel_l0[2*SW-1:SW]), 0);
    $display("load_lat0: lw x6 -> add x7,x6,x0 sel0=%0d", fwd_sel_l0[SW-1:0]);

    // Main vector table
    do_reset();
    run_rows(0, vecs.size() - 1);

    // Halt: reissue the delayed halt (load now in stage 1, no stall)
    id_valid = 1'b1; id_rs_addr = {5'd0, 5'd14}; id_rs_used = 2'b01; id_rd = '0;
    id_rd_we = 1'b0; id_is_load = 1'b0; id_is_halt = 1'b1; ex_mispredict = 1'b0;
    #4;
    chk("halt.issue", int'(issue), 1);
    chk("halt.stall", int'(stall), 0);
    step();
    id_is_halt = 1'b0; id_rs_used = 2'b11; id_rs_addr = {5'd3, 5'd3}; id_rd = 5'd3; id_rd_we = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      id_valid = (n % 2 == 0);
      ex_mispredict = (n % 2 == 1);
      #4;
      chk($sformatf("drain%0d.fetch_hold", n), int'(fetch_hold), 1);
      chk($sformatf("drain%0d.issue", n), int'(issue), 0);
      chk($sformatf("drain%0d.flush", n), int'(flush), 0);
      chk($sformatf("drain%0d.stall", n), int'(stall), 0);
      chk($sformatf("drain%0d.halt", n), int'(halt), (n >= 4) ? 1 : 0);
      $display("halt edge+%0d: fetch_hold=%0b halt=%0b stg_valid=%b", n, fetch_hold, halt, stg_valid);
      step();
    end
    #4;
    chk("halted.stg_valid", int'(stg_valid), 0);
    chk("halted.halt", int'(halt), 1);
    chk("halted.issue", int'(issue), 0);
    step();

    // Reset in the middle of DRAIN
    do_reset();
    id_valid = 1'b1; id_is_halt = 1'b1;
    #4;
    chk("halt2.issue", int'(issue), 1);
    step();
    idle();
    step();
    #4;
    chk("halt2.fetch_hold", int'(fetch_hold), 1);
    step();
    rst = 1'b1;
    step();
    #4;
    chk("midrst.stg_valid", int'(stg_valid), 0);
    chk("midrst.fwd_sel", int'(fwd_sel), 0);
    chk("midrst.halt", int'(halt), 0);
    chk("midrst.fetch_hold", int'(fetch_hold), 0);
    chk("midrst.stall", int'(stall), 0);
    chk("midrst.flush", int'(flush), 0);
    rst = 1'b0;
    step();
    #4;
    chk("postrst.fetch_hold", int'(fetch_hold), 0);
    chk("postrst.halt", int'(halt), 0);
    $display("reset mid-drain: fetch_hold=%0b halt=%0b", fetch_hold, halt);
    step();
    exp_stg = '0;
    run_rows(0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
